// File: rtl/panel_debounce.sv
// panel_debounce: synchronise, debounce and edge-detect WIDTH asynchronous front-panel inputs.
// Latency: SYNC_STAGES + (STABLE-1)*DIV to SYNC_STAGES-1 + STABLE*DIV clocks from input change to out/rise/fall.
// Backpressure: none; rise/fall are single-clock pulses and consumers must sample them every clock.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   in       raw asynchronous inputs, one bit per channel
//   out      debounced level, or push-on/push-off state for TOGGLE channels
//   rise     one-clock pulse on each accepted 0->1
//   fall     one-clock pulse on each accepted 1->0
//   tick     sample strobe, high one clock in every DIV
module panel_debounce #(
    parameter int               WIDTH       = 4,
    parameter int               DIV         = 1000,
    parameter int               STABLE      = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] INVERT      = '0,
    parameter logic [WIDTH-1:0] TOGGLE      = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick
);

    localparam int PW = $clog2(DIV);
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE - 1);

    // ------------------------------------------------------------------
    // Synchroniser chain; stage 0 samples the raw pins.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Inversion happens after synchronisation so active-low keys read as 1 when pressed.
    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    // ------------------------------------------------------------------
    // Sample-tick prescaler.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel stability counters, accepted state, pulses and toggle state.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         stable_q, stable_d;
    logic [WIDTH-1:0]         rise_q, rise_d;
    logic [WIDTH-1:0]         fall_q, fall_d;
    logic [WIDTH-1:0]         tog_q, tog_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        tog_d    = tog_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (tick) begin
                if (s[i] == stable_q[i]) begin
                    // Any agreeing sample restarts the run, which is what rejects glitches.
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s[i];
                    cnt_d[i]    = '0;
                    rise_d[i]   = s[i];
                    fall_d[i]   = ~s[i];
                    if (TOGGLE[i] && s[i]) begin
                        tog_d[i] = ~tog_q[i];
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            tog_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            tog_q    <= tog_d;
        end
    end

    // Toggle channels present their flip-flop state; the rest present the debounced level.
    assign out  = (TOGGLE & tog_q) | (~TOGGLE & stable_q);
    assign rise = rise_q;
    assign fall = fall_q;

endmodule
